// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_scan_ctrl                                              |
// | Description : Byte-to-serial sequencer with programmable pattern scanner.|
// |               Bytes taken over valid/ready are shifted out MSB-first,    |
// |               one bit per clock. The serial stream is matched against a  |
// |               1..PAT_W bit pattern (optional overlap) and matches are    |
// |               counted in a saturating hit counter.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n        clock / asynchronous active-low reset                |
// |   cfg_we            config write strobe (pattern, len, overlap)          |
// |   cfg_pattern       pattern, bit 0 = most recent serial bit              |
// |   cfg_len           pattern length, legal 1..PAT_W                       |
// |   cfg_overlap       1 = overlapping matches are counted                  |
// |   cfg_err           one-cycle pulse after a rejected config write        |
// |   in_valid/in_data  byte source; in_ready completes the handshake        |
// |   ser_vld/ser_dout  serial bit stream, MSB first                         |
// |   busy              high while a byte is being shifted                   |
// |   hit               one-cycle pulse per pattern match                    |
// |   cnt_clr           synchronous clear of hit_cnt (wins over a match)     |
// |   hit_cnt           saturating match count                               |
// +--------------------------------------------------------------------------+
module seq_scan_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [PAT_W-1:0]       cfg_pattern,
  input  logic [$clog2(PAT_W):0] cfg_len,
  input  logic                   cfg_overlap,
  output logic                   cfg_err,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   ser_vld,
  output logic                   ser_dout,
  output logic                   busy,
  output logic                   hit,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       hit_cnt
);

  localparam int c_LEN_W = $clog2(PAT_W) + 1;

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_SHIFT = 1'b1;

  localparam logic [c_LEN_W-1:0] c_PAT_LEN = c_LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

  logic [0:0]         r_state;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_sreg;
  logic [PAT_W-1:0]   r_pattern;
  logic [c_LEN_W-1:0] r_len;
  logic               r_overlap;
  logic [PAT_W-1:0]   r_hist;
  logic [c_LEN_W-1:0] r_fill;
  logic               r_hit;
  logic               r_cfg_err;
  logic [CNT_W-1:0]   r_hit_cnt;

  logic               w_busy;
  logic               w_last;
  logic               w_cfg_legal;
  logic [PAT_W-1:0]   w_hist_nxt;
  logic [PAT_W-1:0]   w_mask;
  logic [c_LEN_W-1:0] w_fill_inc;
  logic               w_match;

  assign w_busy      = (r_state == c_ST_SHIFT);
  assign w_last      = w_busy && (r_bit_idx == 3'd0);
  assign w_cfg_legal = (cfg_len != '0) && (cfg_len <= c_PAT_LEN);

  // A config write in IDLE takes priority over a waiting byte.
  assign in_ready = (!w_busy && !cfg_we) || w_last;

  // The bit currently on ser_dout enters the history at the end of the cycle,
  // so the match is evaluated on the history as it will be after that edge.
  assign w_hist_nxt = {r_hist[PAT_W-2:0], r_sreg[7]};
  // Low-len-bit mask; len == PAT_W shifts every one out, leaving all ones.
  assign w_mask     = ~({PAT_W{1'b1}} << r_len);
  // c_LEN_W holds up to 2*PAT_W-1, so fill+1 cannot overflow.
  assign w_fill_inc = r_fill + c_LEN_W'(1);
  assign w_match    = w_busy && (w_fill_inc >= r_len) &&
                      (((w_hist_nxt ^ r_pattern) & w_mask) == '0);

  // Sequencer: IDLE/SHIFT with a byte shift register, MSB presented first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_ST_IDLE;
      r_bit_idx <= 3'd0;
      r_sreg    <= 8'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (!cfg_we && in_valid) begin
            r_state   <= c_ST_SHIFT;
            r_bit_idx <= 3'd7;
            r_sreg    <= in_data;
          end
        end
        c_ST_SHIFT: begin
          if (r_bit_idx == 3'd0) begin
            if (in_valid) begin
              // Reload on the last bit keeps the serial stream gap-free.
              r_bit_idx <= 3'd7;
              r_sreg    <= in_data;
            end else begin
              r_state <= c_ST_IDLE;
              // Cleared so ser_dout rests at 0 while idle.
              r_sreg  <= 8'd0;
            end
          end else begin
            r_bit_idx <= r_bit_idx - 3'd1;
            r_sreg    <= {r_sreg[6:0], 1'b0};
          end
        end
        default: begin
          r_state   <= c_ST_IDLE;
          r_bit_idx <= 3'd0;
          r_sreg    <= 8'd0;
        end
      endcase
    end
  end

  // Configuration registers and the rejection pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= '0;
      r_len     <= c_PAT_LEN;
      r_overlap <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && (w_busy || !w_cfg_legal);
      if (cfg_we && !w_busy && w_cfg_legal) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
      end
    end
  end

  // Scanner: history and fill persist across bytes and idle gaps; only a
  // legal config write (or reset) restarts them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_hit  <= 1'b0;
    end else begin
      r_hit <= w_match;
      if (cfg_we && !w_busy && w_cfg_legal) begin
        r_hist <= '0;
        r_fill <= '0;
        r_hit  <= 1'b0;
      end else if (w_busy) begin
        r_hist <= w_hist_nxt;
        if (w_match && !r_overlap) begin
          // Non-overlap: the next match must be built from len fresh bits.
          r_fill <= '0;
        end else if (r_fill < c_PAT_LEN) begin
          r_fill <= w_fill_inc;
        end
      end
    end
  end

  // Saturating hit counter; clear has priority over a coincident match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt <= '0;
    end else if (w_match && (r_hit_cnt != c_CNT_MAX)) begin
      r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

  assign ser_vld  = w_busy;
  assign busy     = w_busy;
  assign ser_dout = r_sreg[7];
  assign hit      = r_hit;
  assign cfg_err  = r_cfg_err;
  assign hit_cnt  = r_hit_cnt;

endmodule
`default_nettype wire

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Byte-to-serial sequencer and programmable pattern scanner for the serial sequence-detection path. It accepts bytes over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a serial strobe. It matches a configurable bit pattern of 1..PAT_W bits against the serial stream, with optional overlap, and keeps a saturating hit counter. It is the control front-end that feeds and configures serial detectors.

## Interface
- PAT_W, 8, maximum pattern length in bits (2..16)
- CNT_W, 8, hit counter width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  configuration write strobe
- cfg_pattern  in  PAT_W  pattern; bit 0 = most recent serial bit
- cfg_len  in  $clog2(PAT_W)+1  pattern length; legal 1..PAT_W
- cfg_overlap  in  1  1 = overlapping matches counted
- cfg_err  out  1  one-cycle pulse: config write rejected
- in_valid  in  1  byte available
- in_data  in  8  byte to serialize
- in_ready  out  1  byte accepted when in_valid && in_ready at clock edge
- ser_vld  out  1  serial bit valid
- ser_dout  out  1  serial bit, MSB first
- busy  out  1  high while shifting
- hit  out  1  one-cycle pulse per pattern match
- cnt_clr  in  1  synchronous clear of hit_cnt
- hit_cnt  out  CNT_W  saturating match count

## Operation
- Reset values:
  - state IDLE; all outputs 0
  - pattern 0, len PAT_W, overlap 0
  - history 0, fill 0
- States:
  - IDLE: wait for a config write or a byte.
  - SHIFT: 8 cycles, bit_idx 7→0.
- IDLE transitions:
  - cfg_we: apply or reject the config; stay in IDLE.
  - Otherwise, an accepted byte moves to SHIFT with bit_idx=7.
- In SHIFT, at bit_idx=0:
  - Byte accepted: reload and stay in SHIFT, bit_idx=7, with no gap.
  - No byte: go to IDLE.
- in_ready = (IDLE && !cfg_we) || (SHIFT && bit_idx==0). If cfg_we and in_valid are both high in IDLE, the config is taken and the byte is not.
- Config write:
  - Legal cfg_len in IDLE: load pattern, len and overlap; clear history, fill and hit state. No pulse.
  - cfg_len==0, cfg_len>PAT_W, or cfg_we while busy: registers unchanged; cfg_err pulses in the following cycle.
- ser_vld and busy are high in every SHIFT cycle. ser_dout = byte[bit_idx].
- Scanner, on each SHIFT cycle:
  - hist <= {hist[PAT_W-2:0], ser_dout}.
  - fill increments, saturating at PAT_W.
  - Match when (fill+1) >= len and the low len bits of the new hist equal the low len bits of the pattern.
- Matching history persists across bytes and idle gaps. Only reset or a legal config write clears it.
- Non-overlap mode: on a match, fill is cleared to 0, so the next match needs len fresh bits.
- hit_cnt:
  - +1 on each match; holds at 2^CNT_W-1 (no wrap).
  - cnt_clr sets it to 0; cnt_clr wins over a simultaneous match.
- Reset asserted mid-shift: immediate return to IDLE and reset values; the partial byte is dropped.

## Timing
- Byte accepted at edge E0: serial bits occupy cycles 1..8 after E0, MSB in cycle 1.
- Sustained throughput: one byte per 8 cycles; ser_vld stays continuously high while in_valid stays high.
- hit latency: hit is high in the cycle after the ser_vld cycle that carries the last matching bit. hit_cnt shows the new value in that same cycle.
- cfg_err latency: 1 cycle after the rejected cfg_we.
- Outputs other than in_ready are registered.

## Test plan
- Reset, then idle:
  - All outputs 0 and in_ready=1.
  - Assert rst_n low during SHIFT → ser_vld, busy and hit drop to 0 immediately, with no clock edge needed.
- Pattern 4'b1101, len 4, overlap 1; send 0xDB:
  - ser_dout sequence 1,1,0,1,1,0,1,1.
  - hit in cycles 5 and 8 after acceptance; hit_cnt=2.
- Pattern 3'b101, len 3; send 0xAA:
  - Overlap 1 → 3 hits, in cycles 4, 6 and 8.
  - Overlap 0 → 2 hits, in cycles 4 and 8.
- Back-to-back, pattern 8'hFF, len 8; in_valid held with 0x0F then 0xF0:
  - Second byte accepted on the last bit of the first, with no ser_vld gap.
  - Single hit in the cycle after the 4th bit of 0xF0.
- Config errors:
  - cfg_len=0 → cfg_err pulse; old config still matches.
  - cfg_we during SHIFT → cfg_err pulse.
  - cfg_we together with in_valid in IDLE → in_ready=0 and the byte is held.
- Counter, CNT_W=8:
  - Drive 260 matches → hit_cnt stays at 255.
  - cnt_clr in the same cycle as a match → hit_cnt=0.
